// File: rtl/wave_sum_tree.sv
// Pipelined signed adder tree mixing NUM_CH channels into one saturated sample.
// Optional clip counter is built when WAVE_SUM_CLIP_COUNT_EN is defined.
module wave_sum_tree #(
  parameter int NUM_CH   = 32,
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*SAMPLE_W-1:0]   samples,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic                         in_valid,
  input  logic                         clip_clr,
  output logic [OUT_W-1:0]             out_sample,
  output logic                         out_valid,
  output logic                         clip,
  output logic                         clip_sticky,
  output logic [15:0]                  clip_count
);

  localparam int LEVELS = $clog2(NUM_CH);
  localparam int SW     = SAMPLE_W + LEVELS;
  localparam int XW     = ((SW > OUT_W) ? SW : OUT_W) + 1;

  // All tree levels live in one flat vector; level 0 is the masked input.
  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int j = 0; j < l; j++) o += (NUM_CH >> j) * (SAMPLE_W + j);
    return o;
  endfunction

  localparam int TOT      = lvl_off(LEVELS + 1);
  localparam int OFF_ROOT = lvl_off(LEVELS);

  localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [TOT-1:0] w_tree;

  for (genvar gl = 0; gl <= LEVELS; gl++) begin : g_lvl
    localparam int NN  = NUM_CH >> gl;
    localparam int W   = SAMPLE_W + gl;
    localparam int OFF = lvl_off(gl);
    if (gl == 0) begin : g_mask
      for (genvar gn = 0; gn < NN; gn++) begin : g_ch
        assign w_tree[OFF + gn*W +: W] = ch_en[gn] ? samples[gn*W +: W] : {W{1'b0}};
      end
    end else begin : g_add
      localparam int POFF = lvl_off(gl - 1);
      logic [NN*W-1:0] w_add;
      logic [NN*W-1:0] r_sum;
      for (genvar gn = 0; gn < NN; gn++) begin : g_node
        logic [W-2:0] w_a;
        logic [W-2:0] w_b;
        assign w_a = w_tree[POFF + (2*gn)*(W-1) +: W-1];
        assign w_b = w_tree[POFF + (2*gn+1)*(W-1) +: W-1];
        // One bit of growth per level keeps every add exact.
        assign w_add[gn*W +: W] = {w_a[W-2], w_a} + {w_b[W-2], w_b};
      end
      // Level register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sum <= {(NN*W){1'b0}};
        else        r_sum <= w_add;
      end
      assign w_tree[OFF +: NN*W] = r_sum;
    end
  end

  logic [LEVELS-1:0]     r_vld;
  logic [LEVELS:0]       w_vld_next;
  logic [SW-1:0]         w_root;
  logic signed [XW-1:0]  w_ext;
  logic signed [XW-1:0]  w_shr;
  logic                  w_hi;
  logic                  w_lo;
  logic [OUT_W-1:0]      w_sat;
  logic                  w_last_vld;
  logic                  w_clip_pulse;

  assign w_vld_next   = {r_vld, in_valid};
  assign w_last_vld   = r_vld[LEVELS-1];
  assign w_root       = w_tree[OFF_ROOT +: SW];
  assign w_ext        = {{(XW-SW){w_root[SW-1]}}, w_root};
  assign w_shr        = w_ext >>> SHIFT;
  assign w_hi         = (w_shr > MAXV);
  assign w_lo         = (w_shr < MINV);
  assign w_clip_pulse = w_last_vld & (w_hi | w_lo);

  // Saturate the attenuated sum into the output range.
  always_comb begin
    w_sat = w_shr[OUT_W-1:0];
    if (w_hi)      w_sat = MAXV[OUT_W-1:0];
    else if (w_lo) w_sat = MINV[OUT_W-1:0];
    else           w_sat = w_shr[OUT_W-1:0];
  end

  // Valid bit shadows the data through every tree level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_vld <= {LEVELS{1'b0}};
    else        r_vld <= w_vld_next[LEVELS-1:0];
  end

  logic [OUT_W-1:0] r_out;
  logic             r_out_vld;
  logic             r_clip;
  logic             r_sticky;

  // Output stage: sample holds across bubbles, clip only pulses with valid data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out     <= {OUT_W{1'b0}};
      r_out_vld <= 1'b0;
      r_clip    <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_out_vld <= w_last_vld;
      r_clip    <= w_clip_pulse;
      if (w_last_vld) r_out <= w_sat;
      else            r_out <= r_out;
      if (w_clip_pulse)  r_sticky <= 1'b1;
      else if (clip_clr) r_sticky <= 1'b0;
      else               r_sticky <= r_sticky;
    end
  end

  assign out_sample  = r_out;
  assign out_valid   = r_out_vld;
  assign clip        = r_clip;
  assign clip_sticky = r_sticky;

`ifdef WAVE_SUM_CLIP_COUNT_EN
  logic [15:0] r_cnt;

  // Saturating clip counter; a clip coinciding with clear counts as the first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 16'h0000;
    end else if (w_clip_pulse) begin
      if (clip_clr)               r_cnt <= 16'h0001;
      else if (r_cnt == 16'hFFFF) r_cnt <= r_cnt;
      else                        r_cnt <= r_cnt + 16'h0001;
    end else if (clip_clr) begin
      r_cnt <= 16'h0000;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign clip_count = r_cnt;
`else
  assign clip_count = 16'h0000;
`endif

endmodule

// File: doc/wave_sum_tree.md
Name: wave_sum_tree

Overview:
- Parametrised, pipelined adder tree that mixes NUM_CH signed oscillator samples into one signed output sample.
- Sits between the per-channel oscillator blocks and the DAC/output stage, replacing fixed-width two-input combinational summing.
- Adds per-channel enable, full-precision internal growth, programmable attenuation shift, output saturation with clip reporting, and valid tracking through the pipeline.

Parameters:
- NUM_CH, 32, channel count; power of two, >= 2.
- SAMPLE_W, 16, width of each signed input sample.
- OUT_W, 16, width of the signed output sample.
- SHIFT, 0, arithmetic right shift applied to the full-precision sum before saturation; range 0..log2(NUM_CH).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- samples  input  NUM_CH*SAMPLE_W  packed signed samples; channel k in bits [k*SAMPLE_W +: SAMPLE_W].
- ch_en  input  NUM_CH  per-channel enable; 0 forces that channel's contribution to 0.
- in_valid  input  1  samples/ch_en are valid this cycle.
- out_sample  output  OUT_W  signed mixed, saturated result.
- out_valid  output  1  out_sample was updated this cycle.
- clip  output  1  single-cycle pulse, coincident with out_valid, when the current output saturated.
- clip_sticky  output  1  latched clip indicator.
- clip_clr  input  1  synchronous clear of clip_sticky (and clip_count when enabled).
- clip_count  output  16  number of clipped output samples.

Behaviour:
- LEVELS = log2(NUM_CH). Level L (1..LEVELS) is a registered stage holding NUM_CH/2^L sums of width SAMPLE_W+L; each add is sign-extended and exact, so no internal overflow.
- Masking is combinational ahead of level 1: channel k contributes samples[k] if ch_en[k], else 0. ch_en is sampled in the same cycle as its samples.
- Output stage (registered): s = sum >>> SHIFT (arithmetic); if s > 2^(OUT_W-1)-1, then out = max and clip = 1; if s < -2^(OUT_W-1), then out = min and clip = 1; otherwise out = s[OUT_W-1:0].
- Latency: LEVELS+1 cycles from in_valid to out_valid (6 for NUM_CH=32). Throughput is one sample per cycle; there is no stall or backpressure.
- A valid bit travels alongside the data through every stage. Data registers may load every cycle, but out_sample and clip update only when the final valid bit is 1; otherwise out_sample holds its last value and clip = 0.
- clip_sticky is set on any clip pulse and cleared by clip_clr. If set and clear occur in the same cycle, set wins, so clip_sticky = 1.
- Asynchronous reset (reset = 0) forces all pipeline data to 0, all valid bits to 0, and out_sample, out_valid, clip, clip_sticky and clip_count to 0. Reset mid-stream discards all in-flight samples. The first out_valid after reset release arrives LEVELS+1 cycles after the first accepted in_valid.
- in_valid = 0 cycles create bubbles that propagate unchanged; gaps are preserved at the output.
- All channels disabled: output = 0, out_valid still follows in_valid.

Optional Feature:
- Macro WAVE_SUM_CLIP_COUNT_EN.
- Defined: clip_count is a 16-bit counter incremented on each clip pulse and saturating at 0xFFFF (no wrap). clip_clr resets it to 0; if clear and a clip coincide, the result is 1.
- Undefined: no counter logic is built and clip_count is tied to 0.

Test Plan:
- Reset/latency, NUM_CH=32, SHIFT=0: all samples = 1, ch_en = all 1s, a single in_valid pulse -> out_valid exactly 6 cycles later with out_sample = 32, clip = 0.
- Masking: samples[k] = k, ch_en = 32'h0000_00FF -> out_sample = 28; ch_en = 0 -> out_sample = 0 with out_valid still asserted.
- Saturation: all samples = 16'h4000, ch_en = all 1s, SHIFT=0 -> out_sample = 16'h7FFF, clip = 1, clip_sticky = 1. All samples = 16'h8000 -> 16'h8000 with clip. Same stimulus with SHIFT=5 -> 16'h4000 and 16'h8000, no clip.
- Streaming with bubbles: in_valid pattern 1,1,0,1 carrying sums 10, 20, x, 30 -> out_valid pattern 1,1,0,1 with outputs 10, 20, held 20, 30.
- Reset mid-flight: assert reset 3 cycles after in_valid -> outputs and flags go to 0 immediately and no stale out_valid appears after release.
- clip_clr with the macro defined: three clipped samples -> clip_count = 3; clip_clr coincident with a fourth clip -> clip_count = 1, clip_sticky = 1; with the macro undefined -> clip_count stays 0.
